// File: rtl/mem_wb_pkg.sv
// Shared widths, load-op encodings and the MEM/WB stage payload.
package mem_wb_pkg;

    localparam int unsigned DW        = 32;
    localparam int unsigned AW        = 5;
    localparam int unsigned STALL_W   = 6;
    localparam int unsigned LOAD_OP_W = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    localparam logic [LOAD_OP_W-1:0] LOAD_LW  = 3'd0;
    localparam logic [LOAD_OP_W-1:0] LOAD_LB  = 3'd1;
    localparam logic [LOAD_OP_W-1:0] LOAD_LBU = 3'd2;
    localparam logic [LOAD_OP_W-1:0] LOAD_LH  = 3'd3;
    localparam logic [LOAD_OP_W-1:0] LOAD_LHU = 3'd4;

    typedef struct packed {
        logic                 valid;
        logic [AW-1:0]        wd;
        logic                 wreg;
        logic [DW-1:0]        wdata;
        logic                 is_load;
        logic [LOAD_OP_W-1:0] load_op;
        logic [1:0]           addr_lo;
        logic                 whilo;
        logic [DW-1:0]        hi;
        logic [DW-1:0]        lo;
    } mem_entry_t;

endpackage

// File: rtl/mem_wb_load_align.sv
// Big-endian load extraction and sign/zero extension with misalignment detect.
module mem_wb_load_align
    import mem_wb_pkg::*;
(
    input  logic [DW-1:0]        word_i,
    input  logic [LOAD_OP_W-1:0] op_i,
    input  logic [1:0]           addr_lo_i,
    output logic [DW-1:0]        data_o,
    output logic                 err_o
);

    logic [4:0]  byte_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Byte 0 lives in bits 31:24, so the shift is 8 * (3 - addr_lo).
    assign byte_sh = {~addr_lo_i, 3'b000};
    assign byte_v  = word_i[byte_sh +: 8];
    assign half_v  = addr_lo_i[1] ? word_i[15:0] : word_i[31:16];

    always_comb begin
        data_o = word_i;
        err_o  = 1'b0;
        case (op_i)
            LOAD_LB:  data_o = {{(DW-8){byte_v[7]}}, byte_v};
            LOAD_LBU: data_o = {{(DW-8){1'b0}}, byte_v};
            LOAD_LH: begin
                data_o = {{(DW-16){half_v[15]}}, half_v};
                err_o  = addr_lo_i[0];
            end
            LOAD_LHU: begin
                data_o = {{(DW-16){1'b0}}, half_v};
                err_o  = addr_lo_i[0];
            end
            LOAD_LW:  err_o = (addr_lo_i != 2'b00);
            default:  data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: load alignment, regfile write port and HI/LO state.
module mem_wb
    import mem_wb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic [AW-1:0]        mem_wd,
    input  logic                 mem_wreg,
    input  logic [DW-1:0]        mem_wdata,
    input  logic                 mem_is_load,
    input  logic [LOAD_OP_W-1:0] mem_load_op,
    input  logic [1:0]           mem_addr_lo,
    input  logic                 mem_whilo,
    input  logic [DW-1:0]        mem_hi,
    input  logic [DW-1:0]        mem_lo,
    input  logic [DW-1:0]        dmem_rdata,
    output logic                 wb_we,
    output logic [AW-1:0]        wb_waddr,
    output logic [DW-1:0]        wb_wdata,
    output logic                 wb_align_err,
    output logic [DW-1:0]        hi_o,
    output logic [DW-1:0]        lo_o
);

    mem_entry_t    entry_q, entry_d;
    logic [DW-1:0] cap_q, cap_d;
    logic          cap_flag_q, cap_flag_d;
    logic [DW-1:0] hi_q, lo_q;
    logic [DW-1:0] align_src;
    logic [DW-1:0] aligned;
    logic          align_err_raw;
    logic          load_err;
    logic          unused_stall;

    assign unused_stall = ^stall[STALL_MEM-1:0];

    // Stage update: flush/bubble beats capture beats hold; RAM word latched on first held cycle.
    always_comb begin
        entry_d    = entry_q;
        cap_d      = cap_q;
        cap_flag_d = cap_flag_q;
        if (flush || (stall[STALL_MEM] && !stall[STALL_WB])) begin
            entry_d    = '0;
            cap_flag_d = 1'b0;
        end else if (!stall[STALL_MEM]) begin
            entry_d = '{valid:   1'b1,
                        wd:      mem_wd,
                        wreg:    mem_wreg,
                        wdata:   mem_wdata,
                        is_load: mem_is_load,
                        load_op: mem_load_op,
                        addr_lo: mem_addr_lo,
                        whilo:   mem_whilo,
                        hi:      mem_hi,
                        lo:      mem_lo};
            cap_flag_d = 1'b0;
        end else if (entry_q.valid && entry_q.is_load && !cap_flag_q) begin
            cap_d      = dmem_rdata;
            cap_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q    <= '0;
            cap_q      <= '0;
            cap_flag_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            entry_q    <= entry_d;
            cap_q      <= cap_d;
            cap_flag_q <= cap_flag_d;
            if (entry_q.valid && entry_q.whilo) begin
                hi_q <= entry_q.hi;
                lo_q <= entry_q.lo;
            end
        end
    end

    assign align_src = cap_flag_q ? cap_q : dmem_rdata;

    mem_wb_load_align u_load_align (
        .word_i    (align_src),
        .op_i      (entry_q.load_op),
        .addr_lo_i (entry_q.addr_lo),
        .data_o    (aligned),
        .err_o     (align_err_raw)
    );

    assign load_err     = entry_q.valid & entry_q.is_load & align_err_raw;
    assign wb_align_err = load_err;
    assign wb_we        = entry_q.valid & entry_q.wreg & ~load_err;
    assign wb_waddr     = entry_q.valid ? entry_q.wd : '0;
    assign wb_wdata     = !entry_q.valid  ? '0 :
                          entry_q.is_load ? aligned : entry_q.wdata;

    // Same-cycle bypass so a reader in this cycle sees the value being committed.
    assign hi_o = (entry_q.valid && entry_q.whilo) ? entry_q.hi : hi_q;
    assign lo_o = (entry_q.valid && entry_q.whilo) ? entry_q.lo : lo_q;

endmodule

// File: tb/tb_mem_wb.sv
// Directed scoreboard bench for the MEM/WB stage.
module tb_mem_wb;
    import mem_wb_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [STALL_W-1:0]   stall;
    logic                 flush;
    logic [AW-1:0]        mem_wd;
    logic                 mem_wreg;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_is_load;
    logic [LOAD_OP_W-1:0] mem_load_op;
    logic [1:0]           mem_addr_lo;
    logic                 mem_whilo;
    logic [DW-1:0]        mem_hi;
    logic [DW-1:0]        mem_lo;
    logic [DW-1:0]        dmem_rdata;
    logic                 wb_we;
    logic [AW-1:0]        wb_waddr;
    logic [DW-1:0]        wb_wdata;
    logic                 wb_align_err;
    logic [DW-1:0]        hi_o;
    logic [DW-1:0]        lo_o;

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    mem_wb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_is_load  (mem_is_load),
        .mem_load_op  (mem_load_op),
        .mem_addr_lo  (mem_addr_lo),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .dmem_rdata   (dmem_rdata),
        .wb_we        (wb_we),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .wb_align_err (wb_align_err),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic idle();
        flush       = 1'b0;
        mem_wd      = '0;
        mem_wreg    = 1'b0;
        mem_wdata   = '0;
        mem_is_load = 1'b0;
        mem_load_op = LOAD_LW;
        mem_addr_lo = 2'b00;
        mem_whilo   = 1'b0;
        mem_hi      = '0;
        mem_lo      = '0;
    endtask

    task automatic drive(input logic [AW-1:0] wd, input logic wreg, input logic [DW-1:0] wdata,
                         input logic is_load, input logic [LOAD_OP_W-1:0] op, input logic [1:0] alo,
                         input logic whilo, input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        mem_wd      = wd;
        mem_wreg    = wreg;
        mem_wdata   = wdata;
        mem_is_load = is_load;
        mem_load_op = op;
        mem_addr_lo = alo;
        mem_whilo   = whilo;
        mem_hi      = hi;
        mem_lo      = lo;
    endtask

    task automatic push(input logic we, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                        input logic err);
        exp_t e;
        e.we = we; e.waddr = waddr; e.wdata = wdata; e.err = err;
        sb.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".we"},    32'(wb_we),        32'(e.we));
            chk({tag, ".waddr"}, 32'(wb_waddr),     32'(e.waddr));
            chk({tag, ".wdata"}, wb_wdata,          e.wdata);
            chk({tag, ".err"},   32'(wb_align_err), 32'(e.err));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load through WB with the RAM word presented in its first WB cycle.
    task automatic load_case(input string tag, input logic [LOAD_OP_W-1:0] op, input logic [1:0] alo,
                             input logic [DW-1:0] word, input logic [DW-1:0] exp_data,
                             input logic exp_err);
        drive(5'd3, 1'b1, 32'hDEAD_0000, 1'b1, op, alo, 1'b0, '0, '0);
        push(!exp_err, 5'd3, exp_data, exp_err);
        tick();
        idle();
        dmem_rdata = word;
        #1 check_wb(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        stall      = '0;
        dmem_rdata = '0;
        idle();
        #2;
        chk("reset.we", 32'(wb_we), 32'd0);
        chk("reset.hi", hi_o, 32'd0);
        chk("reset.lo", lo_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU writeback
        drive(5'd5, 1'b1, 32'h0000_1234, 1'b0, LOAD_LW, 2'b00, 1'b0, '0, '0);
        push(1'b1, 5'd5, 32'h0000_1234, 1'b0);
        tick();
        idle();
        #1 check_wb("alu");

        load_case("lb1",   LOAD_LB,  2'd1, 32'h8899_AABB, 32'hFFFF_FF99, 1'b0);
        load_case("lbu3",  LOAD_LBU, 2'd3, 32'h8899_AABB, 32'h0000_00BB, 1'b0);
        load_case("lhu2",  LOAD_LHU, 2'd2, 32'h8899_AABB, 32'h0000_AABB, 1'b0);
        load_case("lh0",   LOAD_LH,  2'd0, 32'h8899_AABB, 32'hFFFF_8899, 1'b0);
        load_case("lw0",   LOAD_LW,  2'd0, 32'h8899_AABB, 32'h8899_AABB, 1'b0);
        load_case("lw2",   LOAD_LW,  2'd2, 32'h8899_AABB, 32'h8899_AABB, 1'b1);
        load_case("lh1",   LOAD_LH,  2'd1, 32'h8899_AABB, 32'hFFFF_8899, 1'b1);

        // Held load: RAM word vanishes after the first WB cycle
        drive(5'd7, 1'b1, '0, 1'b1, LOAD_LB, 2'd0, 1'b0, '0, '0);
        tick();
        idle();
        stall      = 6'b110000;
        dmem_rdata = 32'h8899_AABB;
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 5'd7, 32'hFFFF_FF88, 1'b0);
            #1 check_wb($sformatf("hold%0d", i));
            tick();
            dmem_rdata = '0;
        end
        stall = '0;
        tick();

        // Entry in WB still writes while MEM stalls; then a bubble follows
        drive(5'd9, 1'b1, 32'h0000_0055, 1'b0, LOAD_LW, 2'd0, 1'b0, '0, '0);
        tick();
        idle();
        stall = 6'b010000;
        push(1'b1, 5'd9, 32'h0000_0055, 1'b0);
        #1 check_wb("stall_in_wb");
        tick();
        push(1'b0, 5'd0, 32'd0, 1'b0);
        check_wb("bubble");
        stall = '0;

        // Flush kills the incoming entry
        drive(5'd10, 1'b1, 32'h0000_0077, 1'b0, LOAD_LW, 2'd0, 1'b0, '0, '0);
        flush = 1'b1;
        tick();
        idle();
        push(1'b0, 5'd0, 32'd0, 1'b0);
        #1 check_wb("flush");

        // HI/LO bypass then committed value
        drive(5'd0, 1'b0, '0, 1'b0, LOAD_LW, 2'd0, 1'b1, 32'h0000_000A, 32'h0000_000B);
        tick();
        idle();
        #1;
        chk("hilo.bypass_hi", hi_o, 32'h0000_000A);
        chk("hilo.bypass_lo", lo_o, 32'h0000_000B);
        tick();
        chk("hilo.reg_hi", hi_o, 32'h0000_000A);
        chk("hilo.reg_lo", lo_o, 32'h0000_000B);

        // Asynchronous reset in the middle of a load
        drive(5'd4, 1'b1, '0, 1'b1, LOAD_LW, 2'd0, 1'b0, '0, '0);
        tick();
        idle();
        dmem_rdata = 32'h0000_0001;
        #1 chk("rstload.pre_we", 32'(wb_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstload.we", 32'(wb_we), 32'd0);
        chk("rstload.hi", hi_o, 32'd0);
        chk("rstload.lo", lo_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstload.post_we", 32'(wb_we), 32'd0);

        chk("sb.drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
